// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: state encoding, source
// indices, default mode mask and the fixed-priority helper.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_e;

  localparam int unsigned IRQ_SYS  = 0;
  localparam int unsigned IRQ_SDC  = 1;
  localparam int unsigned IRQ_HID  = 2;
  localparam int unsigned IRQ_PORT = 3;

  localparam logic [7:0] IRQ_LEVEL_MASK_DEFAULT = 8'h00;

  // Lowest-index set bit wins; 0 when nothing is set.
  function automatic logic [2:0] irq_lowest(input logic [7:1] v);
    irq_lowest = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (v[i]) irq_lowest = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_src_latch.sv
// Single-source pending/overrun latch; LEVEL selects level- or rising-edge
// detection.
module irq_src_latch
  import irq_pkg::*;
#(
  parameter bit LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic enable,
  input  logic ack,
  output logic pend,
  output logic ovr
);

  logic src_q;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic set;

  always_comb begin
    set    = enable & src & (LEVEL | ~src_q);
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (!enable) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end else if (ack) begin
      // A coincident edge event survives the ack; a level request re-latches a cycle later.
      pend_d = set & ~LEVEL;
      ovr_d  = 1'b0;
    end else if (set) begin
      pend_d = 1'b1;
      if (pend_q && !LEVEL) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      src_q  <= src;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend = pend_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source latches, MCU-facing assert/gap sequencer
// and a fixed-priority encoder for irq_valid/irq_id.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [7:0]  LEVEL_MASK = IRQ_LEVEL_MASK_DEFAULT,
  parameter int unsigned GAP_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_src,
  input  logic [7:0] irq_enable,
  input  logic [7:0] int_ack,
  output logic [7:0] int_in,
  output logic [7:0] irq_overrun,
  output logic       irq_valid,
  output logic [2:0] irq_id
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [7:1]  pending;
  logic [7:1]  overrun;
  logic [7:1]  active;
  irq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [2:0]  id_q, id_d;
  logic        unused_bit0;

  for (genvar i = 1; i < 8; i++) begin : g_src
    irq_src_latch #(
      .LEVEL(LEVEL_MASK[i])
    ) u_latch (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[i]),
      .enable(irq_enable[i]),
      .ack   (int_ack[i]),
      .pend  (pending[i]),
      .ovr   (overrun[i])
    );
  end

  assign active      = pending & irq_enable[7:1];
  assign unused_bit0 = ^{irq_src[0], irq_enable[0], int_ack[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      valid_q <= 1'b0;
      id_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = |active;
    id_d    = irq_lowest(active);
    case (state_q)
      ST_IDLE: begin
        if (|active) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (|int_ack[7:1]) begin
          state_d = ST_GAP;
          cnt_d   = 16'd0;
        end else if (!(|active)) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        // Leaving at GAP_LAST keeps the zero window exactly GAP_CYCLES long.
        if (cnt_q == GAP_LAST) begin
          state_d = (|active) ? ST_ASSERT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_in      = (state_q == ST_ASSERT) ? {active, 1'b0} : 8'h00;
    irq_overrun = {overrun, 1'b0};
    irq_valid   = valid_q;
    irq_id      = id_q;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam logic [7:0] LM = 8'h08;
  localparam int         G  = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = 8'h00;
  logic [7:0] irq_enable = 8'h00;
  logic [7:0] int_ack = 8'h00;
  logic [7:0] int_in;
  logic [7:0] irq_overrun;
  logic       irq_valid;
  logic [2:0] irq_id;

  int total = 0;
  int bad = 0;

  irq_ctrl #(.LEVEL_MASK(LM), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq_enable (irq_enable),
    .int_ack    (int_ack),
    .int_in     (int_in),
    .irq_overrun(irq_overrun),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending/overrun per source, plus "asserting" flag and
  // remaining blanking cycles after an acknowledge.
  logic [7:0] m_pend, m_ovr, m_prev;
  logic       m_valid;
  logic [2:0] m_id;
  bit         m_assert;
  int         m_gap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 8'h00; m_ovr = 8'h00; m_prev = 8'h00;
      m_valid = 1'b0; m_id = 3'd0; m_assert = 0; m_gap = 0;
    end else begin
      logic [7:0] act;
      act = m_pend & irq_enable & 8'hFE;
      m_valid = (act != 8'h00);
      m_id = 3'd0;
      for (int i = 7; i >= 1; i--) if (act[i]) m_id = 3'(i);
      if (m_assert) begin
        if ((int_ack & 8'hFE) != 8'h00) begin m_assert = 0; m_gap = G; end
        else if (act == 8'h00) m_assert = 0;
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) m_assert = (act != 8'h00);
      end else begin
        m_assert = (act != 8'h00);
      end
      for (int i = 1; i < 8; i++) begin
        bit evt;
        evt = irq_enable[i] && irq_src[i] && (LM[i] || !m_prev[i]);
        if (!irq_enable[i]) begin
          m_pend[i] = 1'b0; m_ovr[i] = 1'b0;
        end else if (int_ack[i]) begin
          m_pend[i] = evt && !LM[i]; m_ovr[i] = 1'b0;
        end else if (evt) begin
          if (m_pend[i] && !LM[i]) m_ovr[i] = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
      m_prev = irq_src;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e_int;
    e_int = m_assert ? (m_pend & irq_enable & 8'hFE) : 8'h00;
    chk("model int_in", int'(int_in), int'(e_int));
    chk("model irq_overrun", int'(irq_overrun), int'(m_ovr));
    chk("model irq_valid", int'(irq_valid), int'(m_valid));
    chk("model irq_id", int'(irq_id), int'(m_id));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nonzero(input string name);
    int n;
    n = 0;
    while (int_in == 8'h00 && n < 100) begin n++; tick(); end
    chk(name, (n < 100) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset int_in", int'(int_in), 0);
    chk("reset overrun", int'(irq_overrun), 0);
    chk("reset valid", int'(irq_valid), 0);
    chk("reset id", int'(irq_id), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Edge source 1
    irq_enable = 8'h02;
    irq_src = 8'h02; tick();
    chk("edge1 idle after set", int'(int_in), 0);
    irq_src = 8'h00; tick();
    chk("edge1 int_in", int'(int_in), 8'h02);
    chk("edge1 id", int'(irq_id), 1);
    int_ack = 8'h02; tick(); int_ack = 8'h00;
    chk("edge1 ack blank", int'(int_in), 0);
    repeat (40) tick();
    chk("edge1 idle int_in", int'(int_in), 0);
    chk("edge1 idle valid", int'(irq_valid), 0);

    // Level source 3 held high
    irq_enable = 8'h08; irq_src = 8'h08;
    tick(); tick();
    chk("lvl3 int_in", int'(int_in), 8'h08);
    int_ack = 8'h08; tick(); int_ack = 8'h00;
    n = 0;
    while (int_in == 8'h00 && n < 100) begin n++; tick(); end
    chk("lvl3 gap length", n, G);
    chk("lvl3 reassert", int'(int_in), 8'h08);
    irq_src = 8'h00; int_ack = 8'h08; tick(); int_ack = 8'h00;
    repeat (40) tick();
    chk("lvl3 dropped idle", int'(int_in), 0);
    chk("lvl3 dropped valid", int'(irq_valid), 0);

    // Sources 2 and 5 together
    irq_enable = 8'hFF; irq_src = 8'h24;
    tick(); tick();
    chk("dual int_in", int'(int_in), 8'h24);
    chk("dual id", int'(irq_id), 2);
    int_ack = 8'h04; tick(); int_ack = 8'h00;
    wait_nonzero("dual reassert wait");
    chk("dual after gap", int'(int_in), 8'h20);
    chk("dual after gap id", int'(irq_id), 5);
    int_ack = 8'h20; tick(); int_ack = 8'h00; irq_src = 8'h00;
    repeat (40) tick();

    // Overrun and ack/event collision on source 1
    irq_enable = 8'h02;
    irq_src = 8'h02; tick(); irq_src = 8'h00; tick();
    irq_src = 8'h02; tick(); irq_src = 8'h00; tick();
    chk("ovr set", int'(irq_overrun), 8'h02);
    int_ack = 8'h02; irq_src = 8'h02; tick(); int_ack = 8'h00; irq_src = 8'h00;
    chk("ovr cleared", int'(irq_overrun), 0);
    wait_nonzero("collision reassert wait");
    chk("collision kept pending", int'(int_in), 8'h02);
    int_ack = 8'h02; tick(); int_ack = 8'h00;
    repeat (40) tick();

    // Disable while asserted
    irq_enable = 8'h10;
    irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
    chk("dis int_in", int'(int_in), 8'h10);
    irq_enable = 8'h00; #1;
    chk("dis int_in comb", int'(int_in), 0);
    tick(); tick();
    chk("dis valid", int'(irq_valid), 0);
    irq_enable = 8'h10; tick(); tick();
    chk("dis no survive", int'(int_in), 0);

    // Reset during GAP
    irq_enable = 8'h06;
    irq_src = 8'h06; tick(); irq_src = 8'h00; tick();
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    int_ack = 8'h02; tick(); int_ack = 8'h00;
    repeat (5) tick();
    chk("gap overrun", int'(irq_overrun), 8'h04);
    chk("gap id", int'(irq_id), 2);
    #2 reset = 1'b1; #1;
    chk("rst int_in", int'(int_in), 0);
    chk("rst overrun", int'(irq_overrun), 0);
    chk("rst valid", int'(irq_valid), 0);
    chk("rst id", int'(irq_id), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) tick();
    chk("rst no survive", int'(irq_valid), 0);

    // Randomized traffic
    irq_enable = 8'hFE;
    for (int c = 0; c < 3000; c++) begin
      tick();
      irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 63) == 0) irq_enable = 8'($urandom);
      int_ack = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1; #1 reset = 1'b0;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
